// File: rtl/mem_arbiter.sv
// Round-robin N-channel arbiter merging requestor memory ports onto one downstream port.
// Optional watchdog abort enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH-1:0]          req_instr,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [NUM_CH-1:0]          req_err,
  output logic                       mem_valid,
  output logic                       mem_instr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int GNT_W  = $clog2(NUM_CH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (NUM_CH < 2 || TIMEOUT < 2 || (DATA_W % 8) != 0) begin : g_param_check
    $error("mem_arbiter: illegal parameters (NUM_CH>=2, TIMEOUT>=2, DATA_W multiple of 8)");
  end

  logic [0:0]       state;
  logic [GNT_W-1:0] grant;
  logic [GNT_W-1:0] ptr;
  logic             found;
  logic [GNT_W-1:0] winner;
  logic [GNT_W-1:0] next_ptr;
  logic             timeout_hit;
  logic             complete;

  // Rotating priority scan: first valid channel at or after ptr, wrapping past NUM_CH-1.
  always_comb begin : p_scan
    int               idx;
    logic [GNT_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = GNT_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_ptr = (winner == GNT_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_count;

  // A real mem_ready in the limit cycle takes precedence, so the abort is qualified by !mem_ready.
  assign timeout_hit = (state == BUSY) && !mem_ready && (wd_count == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_count <= '0;
    end else if (state == IDLE) begin
      if (found) wd_count <= '0;
    end else if (!mem_ready && !timeout_hit) begin
      wd_count <= wd_count + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state == BUSY) && !rst && (mem_ready || timeout_hit);

  always_comb begin
    req_ready = '0;
    req_err   = '0;
    if (complete) begin
      req_ready[grant] = 1'b1;
      req_err[grant]   = timeout_hit;
    end
  end

  assign req_rdata = timeout_hit ? '0 : mem_rdata;

  // Payload is latched once at grant and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state     <= BUSY;
        grant     <= winner;
        ptr       <= next_ptr;
        mem_valid <= 1'b1;
        mem_instr <= req_instr[winner];
        mem_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[winner*DATA_W +: DATA_W];
        mem_wstrb <= req_wstrb[winner*STRB_W +: STRB_W];
      end
    end else begin
      if (mem_ready || timeout_hit) begin
        state     <= IDLE;
        mem_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TO  = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_instr;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*SW-1:0] req_wstrb;
  logic [DW-1:0]     req_rdata;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    req_err;
  logic              mem_valid;
  logic              mem_instr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [SW-1:0]     mem_wstrb;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
    .req_ready(req_ready), .req_err(req_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Reference model: one transaction in flight, a rotating start pointer, a wait counter.
  bit            m_busy;
  int            m_grant;
  int            m_ptr;
  int            m_wait;
  logic          m_instr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;

  logic [NCH-1:0] obs_ready;
  logic [NCH-1:0] obs_err;
  logic [DW-1:0]  obs_rdata;
  int             obs_q[$];
  bit             pending[NCH];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic valid, input logic instr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] wstrb);
    req_valid[ch]            = valid;
    req_instr[ch]            = instr;
    req_addr[ch*AW +: AW]    = addr;
    req_wdata[ch*DW +: DW]   = wdata;
    req_wstrb[ch*SW +: SW]   = wstrb;
  endtask

  function automatic int pick();
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check the current cycle against the model, advance the model, cross the edge.
  task automatic step();
    logic [NCH-1:0] exp_ready;
    logic [NCH-1:0] exp_err;
    logic           to_hit;
    int             w;
    #2;
    to_hit    = TO_EN && m_busy && !mem_ready && (m_wait == TO - 1);
    exp_ready = '0;
    exp_err   = '0;
    if (!rst && m_busy && (mem_ready || to_hit)) begin
      exp_ready[m_grant] = 1'b1;
      exp_err[m_grant]   = to_hit;
    end
    checkOutput("mem_valid", mem_valid, m_busy);
    if (m_busy) begin
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_wdata", mem_wdata, m_wdata);
      checkOutput("mem_wstrb", mem_wstrb, m_wstrb);
      checkOutput("mem_instr", mem_instr, m_instr);
    end
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("req_err", req_err, exp_err);
    if (|exp_ready) checkOutput("req_rdata", req_rdata, to_hit ? '0 : mem_rdata);
    obs_ready = req_ready;
    obs_err   = req_err;
    obs_rdata = req_rdata;
    for (int i = 0; i < NCH; i++) if (req_ready[i]) obs_q.push_back(i);
    if (rst) begin
      m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_wait = 0;
    end else if (!m_busy) begin
      w = pick();
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_grant = w;
        m_ptr   = (w + 1) % NCH;
        m_wait  = 0;
        m_instr = req_instr[w];
        m_addr  = req_addr[w*AW +: AW];
        m_wdata = req_wdata[w*DW +: DW];
        m_wstrb = req_wstrb[w*SW +: SW];
      end
    end else if (mem_ready || to_hit) begin
      m_busy = 1'b0;
    end else begin
      m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    for (int i = 0; i < NCH; i++) pending[i] = 1'b0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int            vcnt;
    int            pulses;
    int            other;
    int            fire_at;
    logic          err_seen;
    logic [DW-1:0] got;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata;
    logic [SW-1:0] seen_wstrb;
    logic          seen_instr;

    n_checks = 0; n_fail = 0;
    m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_wait = 0;
    m_instr = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    req_valid = '0; req_instr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0; rst = 1'b1;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_mem_valid", mem_valid, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_wstrb", mem_wstrb, 0);
    checkOutput("rst_mem_instr", mem_instr, 0);
    checkOutput("rst_req_err", req_err, 0);

    $display("[TB] read with wait states");
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b0000);
    vcnt = 0; pulses = 0; other = 0; got = '0; seen_addr = '1; seen_wstrb = '1;
    for (int c = 0; c < 12; c++) begin
      if (mem_valid) begin
        vcnt++;
        seen_addr  = mem_addr;
        seen_wstrb = mem_wstrb;
      end
      mem_ready = mem_valid && (vcnt == 4);
      mem_rdata = mem_ready ? 32'hDEADBEEF : 32'h0;
      step();
      if (obs_ready[0]) begin
        pulses++;
        got = obs_rdata;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      end
      if (obs_ready[1] || obs_ready[2]) other++;
    end
    mem_ready = 1'b0;
    checkOutput("rd_valid_cycles", vcnt, 4);
    checkOutput("rd_addr", seen_addr, 32'h100);
    checkOutput("rd_wstrb", seen_wstrb, 0);
    checkOutput("rd_pulses", pulses, 1);
    checkOutput("rd_rdata", got, 32'hDEADBEEF);
    checkOutput("rd_other_ready", other, 0);

    $display("[TB] write pass-through");
    applyStimulus(1, 1'b1, 1'b0, 32'h2004, 32'h00001234, 4'b0011);
    pulses = 0; seen_addr = '0; seen_wdata = '0; seen_wstrb = '0; seen_instr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (mem_valid) begin
        seen_addr = mem_addr; seen_wdata = mem_wdata;
        seen_wstrb = mem_wstrb; seen_instr = mem_instr;
      end
      mem_ready = mem_valid;
      step();
      if (obs_ready[1]) begin
        pulses++;
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      end
    end
    mem_ready = 1'b0;
    checkOutput("wr_addr", seen_addr, 32'h2004);
    checkOutput("wr_wdata", seen_wdata, 32'h00001234);
    checkOutput("wr_wstrb", seen_wstrb, 4'b0011);
    checkOutput("wr_instr", seen_instr, 0);
    checkOutput("wr_pulses", pulses, 1);

    $display("[TB] round-robin wrap");
    do_reset();
    for (int i = 0; i < NCH; i++) applyStimulus(i, 1'b1, 1'(i & 1), 32'h3000 + i*4, 32'h0, 4'b0000);
    mem_ready = 1'b1;
    obs_q.delete();
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_valid) vcnt++;
      step();
    end
    checkOutput("rr_count", obs_q.size(), 6);
    checkOutput("rr_valid_cycles", vcnt, 6);
    for (int k = 0; k < 6; k++) checkOutput("rr_order", (k < obs_q.size()) ? obs_q[k] : -1, k % NCH);

    $display("[TB] fairness");
    do_reset();
    applyStimulus(0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'b0000);
    applyStimulus(2, 1'b1, 1'b0, 32'h4200, 32'h0, 4'b0000);
    mem_ready = 1'b1;
    obs_q.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      if (obs_ready[0]) applyStimulus(0, 1'b1, 1'b0, 32'h4004 + c*4, 32'h0, 4'b0000);
      if (obs_ready[2]) applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    end
    checkOutput("fair_first", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
    checkOutput("fair_second", (obs_q.size() > 1) ? obs_q[1] : -1, 2);
    checkOutput("fair_third", (obs_q.size() > 2) ? obs_q[2] : -1, 0);

    $display("[TB] reset mid-transaction");
    do_reset();
    applyStimulus(1, 1'b1, 1'b0, 32'h5000, 32'h0, 4'b0000);
    step();
    step();
    checkOutput("midrst_busy", mem_valid, 1);
    req_valid = '0;
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    checkOutput("midrst_no_ready_in_rst", obs_ready, 0);
    rst = 1'b0;
    checkOutput("midrst_valid_low", mem_valid, 0);
    step();
    checkOutput("midrst_no_ready_after", obs_ready, 0);
    for (int i = 0; i < NCH; i++) applyStimulus(i, 1'b1, 1'b0, 32'h6000 + i*4, 32'h0, 4'b0000);
    obs_q.delete();
    step();
    step();
    checkOutput("midrst_ptr_zero", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
    do_reset();

    $display("[TB] watchdog");
    applyStimulus(1, 1'b1, 1'b0, 32'h7000, 32'h0, 4'b0000);
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5A5A5;
    if (TO_EN) begin
      vcnt = 0; fire_at = -1; err_seen = 1'b0; got = '1;
      for (int c = 0; c < 20 && fire_at < 0; c++) begin
        if (mem_valid) vcnt++;
        step();
        if (obs_ready[1]) begin
          fire_at  = vcnt;
          err_seen = obs_err[1];
          got      = obs_rdata;
          applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        end
      end
      checkOutput("to_fire_cycle", fire_at, TO);
      checkOutput("to_err", err_seen, 1);
      checkOutput("to_rdata", got, 0);
      checkOutput("to_valid_low", mem_valid, 0);
      mem_ready = 1'b1;
      step();
      checkOutput("to_late_ready_ignored", obs_ready, 0);
      mem_ready = 1'b0;
    end else begin
      pulses = 0; other = 0;
      for (int c = 0; c < 1000; c++) begin
        step();
        if (|obs_ready) pulses++;
        if (|obs_err) other++;
      end
      checkOutput("nto_still_waiting", mem_valid, 1);
      checkOutput("nto_no_ready", pulses, 0);
      checkOutput("nto_no_err", other, 0);
    end
    do_reset();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pending[i] && ($urandom_range(2) == 0)) begin
          applyStimulus(i, 1'b1, 1'($urandom_range(1)), $urandom,
                        $urandom, ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom));
          pending[i] = 1'b1;
        end
      end
      mem_ready = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
      mem_rdata = $urandom;
      rst       = ($urandom_range(499) == 0);
      step();
      for (int i = 0; i < NCH; i++) begin
        if (obs_ready[i] || rst) begin
          applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
          pending[i] = 1'b0;
        end
      end
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
